// File: rtl/gpio_pkg.sv
// gpio_pkg: shared read-select codes, width limit and bus word type for the GPIO bank
package gpio_pkg;
    localparam logic [1:0] RDSEL_GPI0 = 2'b00;
    localparam logic [1:0] RDSEL_GPI1 = 2'b01;
    localparam logic [1:0] RDSEL_GPO1 = 2'b10;
    localparam logic [1:0] RDSEL_GPO2 = 2'b11;
    localparam int GPIO_MAX_W = 32;
    typedef logic [31:0] gpio_word_t;
endpackage

// File: rtl/gpio_sync.sv
// gpio_sync: STAGES-deep flop-chain synchroniser with synchronous reset
// ports: clk, rst (sync, active-high), d (async pins), q (last flop of the chain)
module gpio_sync #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] ff [STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) ff[i] <= '0;
        end else begin
            ff[0] <= d;
            for (int i = 1; i < STAGES; i++) ff[i] <= ff[i-1];
        end
    end

    assign q = ff[STAGES-1];
endmodule

// File: rtl/gpio_regs.sv
// gpio_regs: GPIO register bank behind the address decoder (two outputs, two synced inputs, read mux)
// ports: clk, rst (sync, active-high), we1/we2 write strobes, rdsel read select, wd write data,
//        gpi0/gpi1 async pins, gpo1/gpo2 output registers, rd zero-extended read data,
//        irq sticky rising-edge interrupt on gpi0 and irq_clr clear (only with macro GPIO_IRQ_EN)
module gpio_regs
    import gpio_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] GPO1_RST = '0,
    parameter logic [WIDTH-1:0] GPO2_RST = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we1,
    input  logic                  we2,
    input  logic [1:0]            rdsel,
    input  logic [GPIO_MAX_W-1:0] wd,
    input  logic [WIDTH-1:0]      gpi0,
    input  logic [WIDTH-1:0]      gpi1,
    output logic [WIDTH-1:0]      gpo1,
    output logic [WIDTH-1:0]      gpo2,
    output gpio_word_t            rd,
    output logic                  irq,
    input  logic                  irq_clr
);
    logic [WIDTH-1:0] s0, s1;
    logic             unused_ok;

    gpio_sync #(.WIDTH(WIDTH), .STAGES(2)) u_sync0 (.clk(clk), .rst(rst), .d(gpi0), .q(s0));
    gpio_sync #(.WIDTH(WIDTH), .STAGES(2)) u_sync1 (.clk(clk), .rst(rst), .d(gpi1), .q(s1));

    always_ff @(posedge clk) begin
        if (rst) begin
            gpo1 <= GPO1_RST;
            gpo2 <= GPO2_RST;
        end else begin
            if (we1) gpo1 <= wd[WIDTH-1:0];
            if (we2) gpo2 <= wd[WIDTH-1:0];
        end
    end

    always_comb begin
        case (rdsel)
            RDSEL_GPI0: rd = gpio_word_t'(s0);
            RDSEL_GPI1: rd = gpio_word_t'(s1);
            RDSEL_GPO1: rd = gpio_word_t'(gpo1);
            RDSEL_GPO2: rd = gpio_word_t'(gpo2);
            default:    rd = 'x;
        endcase
    end

`ifdef GPIO_IRQ_EN
    logic [WIDTH-1:0] s3, status, status_nx, edges;
    logic [1:0]       warm;
    logic             irq_q;

    // edges are masked until the warm-up counter saturates so pins high at reset stay quiet
    always_comb begin
        edges     = (warm == 2'd3) ? (s0 & ~s3) : '0;
        status_nx = (irq_clr ? '0 : status) | edges;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s3     <= '0;
            status <= '0;
            irq_q  <= 1'b0;
            warm   <= 2'd0;
        end else begin
            s3     <= s0;
            status <= status_nx;
            irq_q  <= |status_nx;
            warm   <= warm + {1'b0, warm != 2'd3};
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    assign unused_ok = &{1'b0, wd, irq_clr};
endmodule
